// File: rtl/rr_req_agent_pkg.sv
// rtl/rr_req_agent_pkg.sv - shared constants and types for the round-robin request agent
// Purpose: channel count, default SLICE/QW, per-channel state enum, grant helper.
// Ports: none (package).
package rr_req_agent_pkg;

  localparam int NUM_CH    = 4;
  localparam int DEF_SLICE = 2;
  localparam int DEF_QW    = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } chan_state_t;

  function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/rr_req_chan.sv
// rtl/rr_req_chan.sv - one channel: pending-job counter, slice progress, done/drop pulses
// Purpose: tracks queued jobs and partial service progress for a single channel.
// Ports:
//   c     in   clock (rising edge)
//   r     in   asynchronous active-high reset
//   job   in   one-cycle job-arrival pulse
//   grant in   this channel's grant bit, already qualified as part of a one-hot gnt
//   req   out  channel has pending jobs (registered state only)
//   done  out  one-cycle pulse per completed job
//   drop  out  one-cycle pulse per job lost on a full counter
module rr_req_chan
  import rr_req_agent_pkg::*;
#(
  parameter int SLICE = DEF_SLICE,
  parameter int QW    = DEF_QW
) (
  input  logic c,
  input  logic r,
  input  logic job,
  input  logic grant,
  output logic req,
  output logic done,
  output logic drop
);

  localparam int            PW   = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [PW-1:0] LAST = PW'(SLICE - 1);
  localparam logic [QW-1:0] FULL = '1;

  logic [QW-1:0] cnt, cnt_n;
  logic [PW-1:0] prog, prog_n;
  logic          done_n, drop_n;
  logic          valid, complete;
  chan_state_t   state;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      cnt  <= '0;
      prog <= '0;
      done <= 1'b0;
      drop <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      prog <= prog_n;
      done <= done_n;
      drop <= drop_n;
    end
  end

  always_comb begin
    cnt_n    = cnt;
    prog_n   = prog;
    done_n   = 1'b0;
    drop_n   = 1'b0;
    // A grant on an empty channel is a protocol error and must not move state.
    valid    = grant && (cnt != '0);
    complete = valid && (prog == LAST);

    if (valid) begin
      prog_n = complete ? '0 : prog + PW'(1);
    end

    // An arrival on a completion edge takes the slot just freed, so the
    // count is unchanged and nothing is dropped even when full.
    if (complete) begin
      done_n = 1'b1;
      if (!job) begin
        cnt_n = cnt - QW'(1);
      end
    end else if (job) begin
      if (cnt == FULL) begin
        drop_n = 1'b1;
      end else begin
        cnt_n = cnt + QW'(1);
      end
    end
  end

  always_comb begin
    state = EMPTY;
    if (prog != '0) begin
      state = SERVING;
    end else if (cnt != '0) begin
      state = PENDING;
    end
  end

  // SERVING implies cnt > 0, so "not EMPTY" is exactly cnt != 0.
  assign req = (state != EMPTY);

endmodule

// File: rtl/rr_req_agent.sv
// rtl/rr_req_agent.sv - four-channel request agent for a round-robin arbiter
// Purpose: validates the arbiter grant, keeps the sticky protocol error, and
//          instantiates one rr_req_chan per channel.
// Ports:
//   c       in   clock (rising edge)
//   r       in   asynchronous active-high reset
//   job_in  in   [3:0] per-channel job-arrival pulses
//   gnt     in   [3:0] arbiter grant, expected one-hot or zero
//   req     out  [3:0] per-channel request
//   done    out  [3:0] per-channel completion pulses
//   drop    out  [3:0] per-channel overflow pulses
//   err     out  sticky grant-protocol error
//   busy    out  any channel has pending jobs
module rr_req_agent
  import rr_req_agent_pkg::*;
#(
  parameter int SLICE = DEF_SLICE,
  parameter int QW    = DEF_QW
) (
  input  logic              c,
  input  logic              r,
  input  logic [NUM_CH-1:0] job_in,
  input  logic [NUM_CH-1:0] gnt,
  output logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] drop,
  output logic              err,
  output logic              busy
);

  logic              gnt_onehot;
  logic [NUM_CH-1:0] gnt_ok;
  logic              proto_err;

  assign gnt_onehot = is_onehot(gnt);
  // Multi-bit grants are ignored entirely by every channel.
  assign gnt_ok     = gnt & {NUM_CH{gnt_onehot}};
  assign proto_err  = ((gnt != '0) && !gnt_onehot) || ((gnt & ~req) != '0);
  assign busy       = |req;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      err <= 1'b0;
    end else if (proto_err) begin
      err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    rr_req_chan #(
      .SLICE(SLICE),
      .QW   (QW)
    ) u_chan (
      .c    (c),
      .r    (r),
      .job  (job_in[i]),
      .grant(gnt_ok[i]),
      .req  (req[i]),
      .done (done[i]),
      .drop (drop[i])
    );
  end

endmodule

// File: tb/tb_rr_req_agent.sv
// tb/tb_rr_req_agent.sv - self-checking bench for rr_req_agent
module tb_rr_req_agent;

  localparam int SLICE = 2;
  localparam int QW    = 3;
  localparam int MAXC  = (1 << QW) - 1;

  logic       c = 1'b0;
  logic       r = 1'b1;
  logic [3:0] job_in = '0;
  logic [3:0] gnt = '0;
  logic [3:0] req, done, drop;
  logic       err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: job counts and slice progress as plain integers.
  int         cnt_m [4];
  int         prog_m[4];
  logic [3:0] done_m, drop_m;
  logic       err_m;

  rr_req_agent #(.SLICE(SLICE), .QW(QW)) dut (
    .c(c), .r(r), .job_in(job_in), .gnt(gnt),
    .req(req), .done(done), .drop(drop), .err(err), .busy(busy)
  );

  always #5 c = ~c;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      cnt_m[i]  = 0;
      prog_m[i] = 0;
    end
    done_m = '0;
    drop_m = '0;
    err_m  = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] j, input logic [3:0] g);
    int  ones;
    bit  valid, comp;
    ones = $countones(g);
    if (ones > 1) err_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (g[i] && cnt_m[i] == 0) err_m = 1'b1;
      valid     = g[i] && (ones == 1) && (cnt_m[i] > 0);
      comp      = valid && (prog_m[i] == SLICE - 1);
      done_m[i] = comp;
      drop_m[i] = j[i] && !comp && (cnt_m[i] == MAXC);
      if (valid) prog_m[i] = comp ? 0 : prog_m[i] + 1;
      if (comp && !j[i]) cnt_m[i] = cnt_m[i] - 1;
      else if (!comp && j[i] && cnt_m[i] < MAXC) cnt_m[i] = cnt_m[i] + 1;
    end
  endtask

  function automatic logic [13:0] expv();
    logic [3:0] rq;
    for (int i = 0; i < 4; i++) rq[i] = (cnt_m[i] != 0);
    return {rq, done_m, drop_m, err_m, |rq};
  endfunction

  // Drive inputs away from the edge, advance the model on the edge, settle.
  task automatic cycle(input logic [3:0] j, input logic [3:0] g);
    @(negedge c);
    job_in = j;
    gnt    = g;
    @(posedge c);
    model_edge(j, g);
    #1;
  endtask

  task automatic do_reset();
    @(negedge c);
    r = 1'b1; job_in = '0; gnt = '0;
    model_reset();
    @(posedge c);
    @(negedge c);
    r = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    job_in = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(posedge c); #1;
      n_cmp++;
      if ({req, done, drop, err, busy} !== 14'd0) begin
        n_bad++;
        $display("FAIL reset_hold k=%0d: got %b expected %b", k, {req, done, drop, err, busy}, 14'd0);
      end
    end
    @(negedge c);
    job_in = '0;
    r = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    cycle(4'b0001, 4'b0000);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || req !== 4'b0001) begin
      n_bad++;
      $display("FAIL basic_req: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
    cycle(4'b0000, 4'b0001);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || done !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_grant1: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
    cycle(4'b0000, 4'b0001);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || done !== 4'b0001 || req !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_done: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
    cycle(4'b0000, 4'b0000);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || done !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_after: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
  endtask

  task automatic test_drop();
    int drops;
    drops = 0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(4'b0100, 4'b0000);
      if (drop[2]) drops++;
      n_cmp++;
      if ({req, done, drop, err, busy} !== expv()) begin
        n_bad++;
        $display("FAIL drop_step k=%0d: got %b expected %b", k, {req, done, drop, err, busy}, expv());
      end
    end
    cycle(4'b0000, 4'b0000);
    n_cmp++;
    if (drops !== 2 || req !== 4'b0100) begin
      n_bad++;
      $display("FAIL drop_count: got drops=%0d req=%b expected drops=2 req=0100", drops, req);
    end
  endtask

  task automatic test_full_complete();
    do_reset();
    for (int k = 0; k < 7; k++) cycle(4'b0010, 4'b0000);
    cycle(4'b0000, 4'b0010);
    cycle(4'b0010, 4'b0010);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || done !== 4'b0010 || drop !== 4'b0000) begin
      n_bad++;
      $display("FAIL full_complete: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
    // Still full: a further arrival must be dropped.
    cycle(4'b0010, 4'b0000);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || drop !== 4'b0010) begin
      n_bad++;
      $display("FAIL full_still7: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
  endtask

  task automatic test_err();
    do_reset();
    cycle(4'b0011, 4'b0000);
    cycle(4'b0000, 4'b0011);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_multi: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
    // Multi-bit grant must not have advanced progress: two good grants complete ch0.
    cycle(4'b0000, 4'b0001);
    cycle(4'b0000, 4'b0001);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || done !== 4'b0001 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
    do_reset();
    cycle(4'b0001, 4'b0000);
    cycle(4'b0000, 4'b1000);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_empty: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
    cycle(4'b0000, 4'b0000);
    n_cmp++;
    if ({req, done, drop, err, busy} !== expv() || err !== 1'b1 || req !== 4'b0001) begin
      n_bad++;
      $display("FAIL err_hold: got %b expected %b", {req, done, drop, err, busy}, expv());
    end
  endtask

  task automatic test_arbiter();
    int         ptr, sel, first_edge, last_done_edge, edge_no;
    int         order[$];
    logic [3:0] g;
    do_reset();
    cycle(4'b1111, 4'b0000);
    cycle(4'b1111, 4'b0000);
    ptr = 0; first_edge = -1; last_done_edge = -1; edge_no = 0;
    for (int k = 0; k < 40; k++) begin
      g = '0;
      sel = -1;
      for (int o = 0; o < 4; o++) begin
        if (sel < 0 && cnt_m[(ptr + o) % 4] != 0) sel = (ptr + o) % 4;
      end
      if (sel >= 0) begin
        g[sel] = 1'b1;
        ptr = (sel + 1) % 4;
      end
      if (sel < 0 && done_m == '0) break;
      cycle(4'b0000, g);
      edge_no++;
      if (first_edge < 0 && g != '0) first_edge = edge_no;
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          order.push_back(i);
          last_done_edge = edge_no;
        end
      end
      n_cmp++;
      if ({req, done, drop, err, busy} !== expv()) begin
        n_bad++;
        $display("FAIL arb_step k=%0d: got %b expected %b", k, {req, done, drop, err, busy}, expv());
      end
    end
    n_cmp++;
    if (order.size() != 8) begin
      n_bad++;
      $display("FAIL arb_count: got %0d completions expected 8", order.size());
    end else begin
      for (int n = 0; n < 8; n++) begin
        n_cmp++;
        if (order[n] != n % 4) begin
          n_bad++;
          $display("FAIL arb_order n=%0d: got ch%0d expected ch%0d", n, order[n], n % 4);
        end
      end
    end
    n_cmp++;
    if (last_done_edge - first_edge + 1 > 16 || last_done_edge < 0) begin
      n_bad++;
      $display("FAIL arb_latency: got %0d cycles expected <= 16", last_done_edge - first_edge + 1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(4'b0001, 4'b0000);
    cycle(4'b0000, 4'b0001);
    @(negedge c);
    gnt = 4'b0001;
    job_in = 4'b0001;
    #2;
    r = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({req, done, drop, err, busy} !== 14'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected %b", {req, done, drop, err, busy}, 14'd0);
    end
    @(posedge c); #1;
    n_cmp++;
    if ({req, done, drop, err, busy} !== 14'd0) begin
      n_bad++;
      $display("FAIL async_reset_edge: got %b expected %b", {req, done, drop, err, busy}, 14'd0);
    end
    @(negedge c);
    r = 1'b0; job_in = '0; gnt = '0;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 4'b0000);
      n_cmp++;
      if ({req, done, drop, err, busy} !== expv() || done !== 4'b0000) begin
        n_bad++;
        $display("FAIL async_after k=%0d: got %b expected %b", k, {req, done, drop, err, busy}, expv());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] j, g;
    int         sel, pick, nreq;
    int         cands[$];
    do_reset();
    for (int k = 0; k < 400; k++) begin
      j = 4'($urandom & $urandom);
      g = '0;
      sel = $urandom_range(0, 19);
      cands.delete();
      for (int i = 0; i < 4; i++) if (cnt_m[i] != 0) cands.push_back(i);
      nreq = cands.size();
      if (sel < 16) begin
        if (nreq > 0) begin
          pick = cands[$urandom_range(0, nreq - 1)];
          g[pick] = 1'b1;
        end
      end else if (sel == 19) begin
        g = 4'($urandom);
      end
      cycle(j, g);
      n_cmp++;
      if ({req, done, drop, err, busy} !== expv()) begin
        n_bad++;
        $display("FAIL random k=%0d j=%b g=%b: got %b expected %b", k, j, g, {req, done, drop, err, busy}, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_full_complete();
    test_err();
    test_arbiter();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
